// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg
//   Shared types and constants for the cache-side SRAM responder.
//   - sram_state_e : controller FSM states (Idle=0, Write=1, Read=2, Done=3)
//   - widths       : cache word, read block and SRAM data bus widths
//   - half_index() : byte address -> un-truncated SRAM half-word index
package sram_controller_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWrite = 2'd1,
      StRead  = 2'd2,
      StDone  = 2'd3
   } sram_state_e;

   localparam int unsigned WordW       = 32;
   localparam int unsigned BlockW      = 64;
   localparam int unsigned BusW        = 16;
   localparam int unsigned WritePhases = 2;
   localparam int unsigned ReadPhases  = 4;
   localparam int unsigned PhaseCntW   = 4;
   localparam int unsigned PhaseIdxW   = 2;

   // Offset from the mapped base, in half-words. Callers truncate to the
   // SRAM address width, so addresses below the base wrap to the top.
   function automatic logic [WordW-1:0] half_index(input logic [WordW-1:0] addr,
                                                   input logic [WordW-1:0] base);
      return (addr - base) >> 1;
   endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// sram_phase_timer
//   Paces one SRAM access: counts PHASE_CYCLES clocks per half-word phase and
//   tracks which phase of the access is in progress.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     active            : an access is in progress; counters clear when low
//     is_write          : access is a write (2 phases) rather than a read (4)
//     phase_idx         : current phase number
//     phase_last_cycle  : this is the final clock of the current phase
//     access_last_phase : current phase is the final phase of the access
module sram_phase_timer
   import sram_controller_pkg::*;
#(
   parameter int unsigned PHASE_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 active,
   input  logic                 is_write,
   output logic [PhaseIdxW-1:0] phase_idx,
   output logic                 phase_last_cycle,
   output logic                 access_last_phase
);

   localparam logic [PhaseCntW-1:0] LastCyc    = PhaseCntW'(PHASE_CYCLES - 1);
   localparam logic [PhaseIdxW-1:0] LastWrPh   = PhaseIdxW'(WritePhases - 1);
   localparam logic [PhaseIdxW-1:0] LastRdPh   = PhaseIdxW'(ReadPhases - 1);

   logic [PhaseCntW-1:0] cyc_q, cyc_d;
   logic [PhaseIdxW-1:0] phase_q, phase_d;

   always_comb begin
      phase_last_cycle  = active && (cyc_q == LastCyc);
      access_last_phase = is_write ? (phase_q == LastWrPh) : (phase_q == LastRdPh);
      cyc_d             = '0;
      phase_d           = '0;
      if (active) begin
         if (phase_last_cycle) begin
            cyc_d   = '0;
            phase_d = phase_q + 1'b1;
         end else begin
            cyc_d   = cyc_q + 1'b1;
            phase_d = phase_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q   <= '0;
         phase_q <= '0;
      end else begin
         cyc_q   <= cyc_d;
         phase_q <= phase_d;
      end
   end

   assign phase_idx = phase_q;

endmodule

// File: rtl/sram_controller.sv
// sram_controller
//   Responder between the cache controller and an asynchronous 16-bit SRAM.
//   A 32-bit write is issued as two half-word writes; a 64-bit block read as
//   four half-word reads. ready pulses for one cycle when an access finishes.
//   Ports:
//     clk, rst           : clock, synchronous active-high reset
//     rd_en, wr_en       : request strobes, held until ready (write wins)
//     address            : byte address, held stable for the whole access
//     write_data         : write word, held stable for the whole access
//     read_data          : {word at block+4, word at block+0}, held after read
//     ready              : idle with no request, or the completion cycle
//     SRAM_DQ            : bidirectional SRAM data bus
//     SRAM_ADDR          : SRAM half-word address
//     SRAM_WE_N          : SRAM write strobe, active low
//     SRAM_UB/LB/CE/OE_N : permanently enabled
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter logic [WordW-1:0] BASE_ADDR    = 32'd1024,
   parameter int unsigned      PHASE_CYCLES = 1,
   parameter int unsigned      SRAM_AW      = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [WordW-1:0]   address,
   input  logic [WordW-1:0]   write_data,
   output logic [BlockW-1:0]  read_data,
   output logic               ready,
   inout  wire  [BusW-1:0]    SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_WE_N,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_OE_N
);

   sram_state_e          state_q, state_d;
   logic [BlockW-1:0]    read_data_q, read_data_d;
   logic [SRAM_AW-1:0]   hidx, wr_base, rd_base;
   logic [PhaseIdxW-1:0] phase_idx;
   logic                 phase_last_cycle, access_last_phase;
   logic                 timer_active, is_write;
   logic                 dq_oe;
   logic [BusW-1:0]      dq_out;

   assign hidx    = SRAM_AW'(half_index(address, BASE_ADDR));
   assign wr_base = hidx & ~SRAM_AW'(1);
   assign rd_base = hidx & ~SRAM_AW'(3);

   assign timer_active = (state_q == StWrite) || (state_q == StRead);
   assign is_write     = (state_q == StWrite);

   sram_phase_timer #(
      .PHASE_CYCLES(PHASE_CYCLES)
   ) u_timer (
      .clk              (clk),
      .rst              (rst),
      .active           (timer_active),
      .is_write         (is_write),
      .phase_idx        (phase_idx),
      .phase_last_cycle (phase_last_cycle),
      .access_last_phase(access_last_phase)
   );

   always_comb begin
      state_d     = state_q;
      read_data_d = read_data_q;
      ready       = 1'b0;
      SRAM_ADDR   = '0;
      SRAM_WE_N   = 1'b1;
      dq_oe       = 1'b0;
      dq_out      = '0;
      unique case (state_q)
         StIdle: begin
            ready = !rd_en && !wr_en;
            if (wr_en) begin
               state_d = StWrite;
            end else if (rd_en) begin
               state_d = StRead;
            end
         end
         StWrite: begin
            SRAM_ADDR = wr_base + SRAM_AW'(phase_idx);
            dq_oe     = 1'b1;
            dq_out    = write_data[{phase_idx[0], 4'b0000} +: BusW];
            // Raising WE_N one cycle early lets the SRAM latch while data is
            // still driven; a single-cycle phase has no room for that.
            SRAM_WE_N = (PHASE_CYCLES > 1) && phase_last_cycle;
            if (phase_last_cycle && access_last_phase) begin
               state_d = StDone;
            end
         end
         StRead: begin
            SRAM_ADDR = rd_base + SRAM_AW'(phase_idx);
            if (phase_last_cycle) begin
               read_data_d[{phase_idx, 4'b0000} +: BusW] = SRAM_DQ;
               if (access_last_phase) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            ready   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         read_data_q <= '0;
      end else begin
         state_q     <= state_d;
         read_data_q <= read_data_d;
      end
   end

   assign read_data = read_data_q;
   assign SRAM_DQ   = dq_oe ? dq_out : {BusW{1'bz}};
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (PHASE_CYCLES 1 and 3), each with
// its own SRAM array. A driver issues requests and pushes the expected result
// (computed from a flat half-word reference memory) into a queue; a monitor
// pops and compares whenever an outstanding request completes.
`timescale 1ns/1ps
module tb_sram_controller;

   localparam int unsigned    AW    = 18;
   localparam int unsigned    MEM_N = 1 << AW;
   localparam logic [31:0]    BASE  = 32'd1024;

   typedef struct {
      bit          is_rd;
      logic [63:0] data;
      int          lat;
      int          req_cyc;
      int unsigned wbase;
      logic [31:0] wdata;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst        [2];
   logic          rd_en      [2];
   logic          wr_en      [2];
   logic [31:0]   address    [2];
   logic [31:0]   write_data [2];
   logic [63:0]   read_data  [2];
   logic          ready      [2];
   logic [AW-1:0] sram_addr  [2];
   logic          we_n       [2];
   logic          ub_n       [2];
   logic          lb_n       [2];
   logic          ce_n       [2];
   logic          oe_n       [2];
   wire  [15:0]   dq0;
   wire  [15:0]   dq1;

   logic [15:0]   sram    [2][0:MEM_N-1];
   logic [15:0]   ref_mem [2][0:MEM_N-1];
   logic          rd_drv  [2];
   bit            busy    [2];
   exp_t          exp_q0[$];
   exp_t          exp_q1[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_controller #(.BASE_ADDR(BASE), .PHASE_CYCLES(1), .SRAM_AW(AW)) u_dut0 (
      .clk(clk), .rst(rst[0]), .rd_en(rd_en[0]), .wr_en(wr_en[0]), .address(address[0]),
      .write_data(write_data[0]), .read_data(read_data[0]), .ready(ready[0]), .SRAM_DQ(dq0),
      .SRAM_ADDR(sram_addr[0]), .SRAM_WE_N(we_n[0]), .SRAM_UB_N(ub_n[0]), .SRAM_LB_N(lb_n[0]),
      .SRAM_CE_N(ce_n[0]), .SRAM_OE_N(oe_n[0])
   );

   sram_controller #(.BASE_ADDR(BASE), .PHASE_CYCLES(3), .SRAM_AW(AW)) u_dut1 (
      .clk(clk), .rst(rst[1]), .rd_en(rd_en[1]), .wr_en(wr_en[1]), .address(address[1]),
      .write_data(write_data[1]), .read_data(read_data[1]), .ready(ready[1]), .SRAM_DQ(dq1),
      .SRAM_ADDR(sram_addr[1]), .SRAM_WE_N(we_n[1]), .SRAM_UB_N(ub_n[1]), .SRAM_LB_N(lb_n[1]),
      .SRAM_CE_N(ce_n[1]), .SRAM_OE_N(oe_n[1])
   );

   // SRAM chip models: drive the bus while the bench expects a read.
   assign dq0 = rd_drv[0] ? sram[0][sram_addr[0]] : 16'bz;
   assign dq1 = rd_drv[1] ? sram[1][sram_addr[1]] : 16'bz;

   always @(negedge clk) begin
      if (!we_n[0]) sram[0][sram_addr[0]] = dq0;
      if (!we_n[1]) sram[1][sram_addr[1]] = dq1;
   end

   function automatic int pcyc(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compare on every completion of an outstanding request.
   always @(negedge clk) begin
      exp_t e;
      bit   got;
      for (int i = 0; i < 2; i++) begin
         if (busy[i] && ready[i]) begin
            busy[i] = 1'b0;
            got     = 1'b0;
            if (i == 0 && exp_q0.size() > 0) begin
               e = exp_q0.pop_front(); got = 1'b1;
            end else if (i == 1 && exp_q1.size() > 0) begin
               e = exp_q1.pop_front(); got = 1'b1;
            end
            if (!got) begin
               checks++; errors++;
               $display("FAIL scoreboard: completion on dut%0d with no expectation", i);
            end else begin
               check($sformatf("latency dut%0d", i), 64'(cyc - e.req_cyc), 64'(e.lat));
               if (e.is_rd) begin
                  check($sformatf("read_data dut%0d", i), read_data[i], e.data);
               end else begin
                  check($sformatf("wr_lo dut%0d", i), 64'(sram[i][e.wbase]), 64'(e.wdata[15:0]));
                  check($sformatf("wr_hi dut%0d", i), 64'(sram[i][e.wbase + 1]),
                        64'(e.wdata[31:16]));
               end
            end
         end
      end
   end

   task automatic do_op(input int i, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data);
      exp_t        e;
      int unsigned h, base;
      int          p, nph, n;
      bit          done, exp_we;
      p = pcyc(i);
      h = int'((addr - BASE) >> 1) & (MEM_N - 1);
      e.is_rd = rd && !wr;
      e.wdata = data;
      if (e.is_rd) begin
         base    = h & ~32'd3;
         nph     = 4;
         e.data  = {ref_mem[i][base + 3], ref_mem[i][base + 2],
                    ref_mem[i][base + 1], ref_mem[i][base]};
         e.wbase = 0;
      end else begin
         base    = h & ~32'd1;
         nph     = 2;
         ref_mem[i][base]     = data[15:0];
         ref_mem[i][base + 1] = data[31:16];
         e.wbase = base;
         e.data  = '0;
      end
      e.lat = nph * p + 1;
      @(posedge clk); #1;
      rd_en[i] = rd; wr_en[i] = wr; address[i] = addr; write_data[i] = data;
      rd_drv[i] = e.is_rd;
      e.req_cyc = cyc;
      if (i == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      busy[i] = 1'b1;
      n = 0;
      done = 1'b0;
      while (!done && n < 200) begin
         @(negedge clk);
         if (ready[i]) begin
            done = 1'b1;
         end else if (n >= 1 && n <= nph * p) begin
            check($sformatf("sram_addr dut%0d", i), 64'(sram_addr[i]),
                  64'(base + (n - 1) / p));
            exp_we = e.is_rd ? 1'b1 : (p > 1 && ((n - 1) % p) == p - 1);
            check($sformatf("we_n dut%0d", i), 64'(we_n[i]), 64'(exp_we));
         end
         n++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL timeout dut%0d: ready stayed 0, expected 1 within 200 cycles", i);
         busy[i] = 1'b0;
         if (i == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
      end
      @(posedge clk); #1;
      rd_en[i] = 1'b0; wr_en[i] = 1'b0; rd_drv[i] = 1'b0;
   endtask

   task automatic random_ops(input int i, input int count);
      int          kind;
      logic [31:0] a;
      for (int k = 0; k < count; k++) begin
         kind = int'($urandom_range(0, 2));
         a    = BASE - 32'd16 + 32'($urandom_range(0, 79));
         do_op(i, kind != 0, kind != 1, a, $urandom);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; rd_en[i] = 1'b0; wr_en[i] = 1'b0;
         address[i] = '0; write_data[i] = '0; rd_drv[i] = 1'b0; busy[i] = 1'b0;
      end
      for (int k = 0; k < int'(MEM_N); k++) begin
         sram[0][k] = '0; sram[1][k] = '0; ref_mem[0][k] = '0; ref_mem[1][k] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset ready dut%0d", i), 64'(ready[i]), 64'd1);
         check($sformatf("reset we_n dut%0d", i), 64'(we_n[i]), 64'd1);
         check($sformatf("reset read_data dut%0d", i), read_data[i], 64'd0);
         check($sformatf("reset sram_addr dut%0d", i), 64'(sram_addr[i]), 64'd0);
      end

      // Single-cycle phases: directed cases.
      do_op(0, 1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF);
      do_op(0, 1'b0, 1'b1, 32'd1028, 32'h1234_5678);
      do_op(0, 1'b1, 1'b0, 32'd1028, 32'h0);
      do_op(0, 1'b1, 1'b1, 32'd1032, 32'hA5A5_5A5A);

      // Abort a read in phase 2.
      @(posedge clk); #1;
      rd_en[0] = 1'b1; address[0] = 32'd1024; rd_drv[0] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (sram_addr[0] != AW'(2) && n < 20);
      check("abort reached phase 2", 64'(sram_addr[0]), 64'd2);
      rst[0] = 1'b1; rd_en[0] = 1'b0; rd_drv[0] = 1'b0;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      @(negedge clk);
      check("abort ready", 64'(ready[0]), 64'd1);
      check("abort we_n", 64'(we_n[0]), 64'd1);
      check("abort read_data", read_data[0], 64'd0);
      do_op(0, 1'b1, 1'b0, 32'd1024, 32'h0);
      do_op(0, 1'b0, 1'b1, 32'd1020, 32'h0BAD_CAFE);
      random_ops(0, 40);

      // Three-cycle phases, including the wrap below the base address.
      do_op(1, 1'b1, 1'b0, 32'd1024, 32'h0);
      do_op(1, 1'b0, 1'b1, 32'd1020, 32'hCAFE_F00D);
      do_op(1, 1'b1, 1'b0, 32'd1020, 32'h0);
      do_op(1, 1'b0, 1'b1, 32'd1024, 32'h1357_9BDF);
      do_op(1, 1'b1, 1'b0, 32'd1026, 32'h0);
      random_ops(1, 25);

      repeat (3) @(posedge clk);
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard drain: %0d/%0d left, expected 0", exp_q0.size(),
                  exp_q1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
